// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM round-robin arbiter.
// rr_pick implements the wrapping search that both arbiter instances use.
package ram_arb_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = $clog2(MAX_REQ);

  typedef struct packed {
    logic               found;
    logic [IDX_W-1:0]   idx;
    logic [MAX_REQ-1:0] gnt;
  } rr_pick_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // First requester at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] vld,
                                       input logic [IDX_W-1:0]   ptr,
                                       input int unsigned        n);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (i < n && !r.found) begin
        k = (int'(ptr) + i) % n;
        if (vld[k[IDX_W-1:0]]) begin
          r.found              = 1'b1;
          r.idx                = k[IDX_W-1:0];
          r.gnt[k[IDX_W-1:0]]  = 1'b1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// Client-side bus of the RAM arbiter: write and read request channels plus the read response.
interface ram_rr_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_SIZE = 9,
  parameter int unsigned DATA_SIZE = 72
);
  logic [NUM_REQ-1:0]           wr_vld;
  logic [NUM_REQ-1:0]           wr_rdy;
  logic [NUM_REQ*ADDR_SIZE-1:0] wr_addr;
  logic [NUM_REQ*DATA_SIZE-1:0] wr_data;
  logic [NUM_REQ-1:0]           rd_vld;
  logic [NUM_REQ-1:0]           rd_rdy;
  logic [NUM_REQ*ADDR_SIZE-1:0] rd_addr;
  logic [NUM_REQ-1:0]           rsp_vld;
  logic [DATA_SIZE-1:0]         rsp_data;

  modport master (
    output wr_vld, wr_addr, wr_data, rd_vld, rd_addr,
    input  wr_rdy, rd_rdy, rsp_vld, rsp_data
  );

  modport slave (
    input  wr_vld, wr_addr, wr_data, rd_vld, rd_addr,
    output wr_rdy, rd_rdy, rsp_vld, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant from req and the pointer, pointer moves past the winner.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = idx_w(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    req,
  input  logic            upd,
  output logic [N-1:0]    gnt,
  output logic [IdxW-1:0] gnt_idx
);

  rr_pick_t        pick;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic            unused_pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(req), IDX_W'(ptr_q), N);
    gnt     = rstn ? pick.gnt[N-1:0] : '0;
    gnt_idx = pick.idx[IdxW-1:0];
    ptr_d   = ptr_q;
    if (upd) begin
      ptr_d = (gnt_idx == IdxW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign unused_pick = ^pick;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one simple dual-port RAM between NUM_REQ clients with independent write/read arbiters.
// Read data is passed back to the winner the cycle after its grant.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned ADDR_SIZE = 9,
  parameter int unsigned DATA_SIZE = 72
) (
  input  logic                 clk,
  input  logic                 rstn,
  ram_rr_arbiter_if.slave      cli,
  output logic                 ram_wea,
  output logic [ADDR_SIZE-1:0] ram_addra,
  output logic [DATA_SIZE-1:0] ram_dina,
  output logic                 ram_reb,
  output logic [ADDR_SIZE-1:0] ram_addrb,
  input  logic [DATA_SIZE-1:0] ram_doutb
);

  localparam int unsigned IdxW = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]   wr_gnt, rd_gnt;
  logic [IdxW-1:0]      wr_idx, rd_idx;
  logic                 wr_any, rd_any;
  logic [IdxW-1:0]      rsel_q, rsel_d;
  logic                 rsel_vld_q, rsel_vld_d;
  logic [DATA_SIZE-1:0] rsp_data_q, rsp_data_d;

  assign wr_any = |wr_gnt;
  assign rd_any = |rd_gnt;

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (cli.wr_vld),
    .upd     (wr_any),
    .gnt     (wr_gnt),
    .gnt_idx (wr_idx)
  );

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (cli.rd_vld),
    .upd     (rd_any),
    .gnt     (rd_gnt),
    .gnt_idx (rd_idx)
  );

  // One-hot grants make an AND-OR mux sufficient; idle ports drive zero.
  always_comb begin
    ram_addra = '0;
    ram_dina  = '0;
    ram_addrb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt[i]) begin
        ram_addra = ram_addra | cli.wr_addr[i*ADDR_SIZE +: ADDR_SIZE];
        ram_dina  = ram_dina  | cli.wr_data[i*DATA_SIZE +: DATA_SIZE];
      end
      if (rd_gnt[i]) begin
        ram_addrb = ram_addrb | cli.rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
      end
    end
  end

  assign ram_wea    = wr_any;
  assign ram_reb    = rd_any;
  assign cli.wr_rdy = wr_gnt;
  assign cli.rd_rdy = rd_gnt;

  always_comb begin
    rsel_d      = rd_idx;
    rsel_vld_d  = rd_any;
    rsp_data_d  = rsel_vld_q ? ram_doutb : rsp_data_q;
    cli.rsp_vld = '0;
    if (rsel_vld_q) begin
      cli.rsp_vld[rsel_q] = 1'b1;
    end
    cli.rsp_data = rsp_data_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsel_q     <= '0;
      rsel_vld_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      rsel_q     <= rsel_d;
      rsel_vld_q <= rsel_vld_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with two clients and a read-first registered RAM model.
module tb_ram_rr_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 9;
  localparam int unsigned DW = 72;

  logic          clk;
  logic          rstn;
  logic          ram_wea, ram_reb;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;
  logic [DW-1:0] mem [512];

  int n_cmp;
  int n_fail;

  ram_rr_arbiter_if #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  ram_rr_arbiter #(.NUM_REQ(NR), .ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cli       (bus),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_dina  (ram_dina),
    .ram_reb   (ram_reb),
    .ram_addrb (ram_addrb),
    .ram_doutb (ram_doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first RAM: the read samples the array before the same-edge write lands.
  always @(posedge clk) begin
    if (ram_reb) ram_doutb <= mem[ram_addrb];
    if (ram_wea) mem[ram_addra] <= ram_dina;
  end

  task automatic set_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wr_addr[c*AW +: AW] = a;
    bus.wr_data[c*DW +: DW] = d;
  endtask

  task automatic set_rd(input int c, input logic [AW-1:0] a);
    bus.rd_addr[c*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.wr_vld = 2'b11;
    bus.rd_vld = 2'b11;
    set_wr(0, 9'd0, '0); set_wr(1, 9'd0, '0);
    set_rd(0, 9'd0);     set_rd(1, 9'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.wr_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_wr_rdy: got %b want 00", bus.wr_rdy); end
      n_cmp++; if (bus.rd_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_rd_rdy: got %b want 00", bus.rd_rdy); end
      n_cmp++; if (ram_wea !== 1'b0) begin n_fail++; $display("FAIL reset_wea: got %b want 0", ram_wea); end
      n_cmp++; if (ram_reb !== 1'b0) begin n_fail++; $display("FAIL reset_reb: got %b want 0", ram_reb); end
      n_cmp++; if (bus.rsp_vld !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_vld: got %b want 00", bus.rsp_vld); end
    end
    @(negedge clk); rstn = 1'b1; #1;
    n_cmp++; if (bus.wr_rdy !== 2'b01) begin n_fail++; $display("FAIL release_wr_rdy: got %b want 01", bus.wr_rdy); end
    n_cmp++; if (bus.rd_rdy !== 2'b01) begin n_fail++; $display("FAIL release_rd_rdy: got %b want 01", bus.rd_rdy); end
    @(negedge clk); bus.wr_vld = 2'b00; bus.rd_vld = 2'b00; #1;
    n_cmp++; if (bus.rsp_vld !== 2'b01) begin n_fail++; $display("FAIL release_rsp_vld: got %b want 01", bus.rsp_vld); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    bus.wr_vld = 2'b01; set_wr(0, 9'd5, 72'h0AA); #1;
    n_cmp++; if (bus.wr_rdy !== 2'b01) begin n_fail++; $display("FAIL wr5_rdy: got %b want 01", bus.wr_rdy); end
    n_cmp++; if (ram_wea !== 1'b1) begin n_fail++; $display("FAIL wr5_wea: got %b want 1", ram_wea); end
    n_cmp++; if (ram_addra !== 9'd5) begin n_fail++; $display("FAIL wr5_addra: got %0d want 5", ram_addra); end
    n_cmp++; if (ram_dina !== 72'h0AA) begin n_fail++; $display("FAIL wr5_dina: got %h want 0aa", ram_dina); end
    @(negedge clk); bus.wr_vld = 2'b00; bus.rd_vld = 2'b01; set_rd(0, 9'd5); #1;
    n_cmp++; if (ram_wea !== 1'b0 || ram_addra !== 9'd0) begin n_fail++; $display("FAIL idle_wr: got wea=%b addra=%0d want 0/0", ram_wea, ram_addra); end
    n_cmp++; if (bus.rd_rdy !== 2'b01) begin n_fail++; $display("FAIL rd5_rdy: got %b want 01", bus.rd_rdy); end
    n_cmp++; if (ram_reb !== 1'b1 || ram_addrb !== 9'd5) begin n_fail++; $display("FAIL rd5_ram: got reb=%b addrb=%0d want 1/5", ram_reb, ram_addrb); end
    @(negedge clk); bus.rd_vld = 2'b00; #1;
    n_cmp++; if (bus.rsp_vld !== 2'b01) begin n_fail++; $display("FAIL rd5_rsp_vld: got %b want 01", bus.rsp_vld); end
    n_cmp++; if (bus.rsp_data !== 72'h0AA) begin n_fail++; $display("FAIL rd5_rsp_data: got %h want 0aa", bus.rsp_data); end
    @(negedge clk); #1;
    n_cmp++; if (bus.rsp_vld !== 2'b00) begin n_fail++; $display("FAIL rd5_rsp_drop: got %b want 00", bus.rsp_vld); end
    n_cmp++; if (bus.rsp_data !== 72'h0AA) begin n_fail++; $display("FAIL rd5_rsp_hold: got %h want 0aa", bus.rsp_data); end
  endtask

  task automatic test_write_alternate();
    logic [1:0]    exp_gnt;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    // A solo client-1 write parks the write pointer at client 0.
    @(negedge clk); bus.wr_vld = 2'b10; set_wr(0, 9'd1, 72'h11); set_wr(1, 9'd2, 72'h22); #1;
    n_cmp++; if (bus.wr_rdy !== 2'b10) begin n_fail++; $display("FAIL solo_c1_wr: got %b want 10", bus.wr_rdy); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); bus.wr_vld = 2'b11; #1;
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 9'd1 : 9'd2;
      exp_data = (i % 2 == 0) ? 72'h11 : 72'h22;
      n_cmp++; if (bus.wr_rdy !== exp_gnt) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %b want %b", i, bus.wr_rdy, exp_gnt); end
      n_cmp++; if (ram_addra !== exp_addr || ram_dina !== exp_data) begin n_fail++; $display("FAIL alt_ram[%0d]: got %0d/%h want %0d/%h", i, ram_addra, ram_dina, exp_addr, exp_data); end
    end
    @(negedge clk); bus.wr_vld = 2'b00;
  endtask

  task automatic test_back_to_back();
    logic [1:0]    exp_vld;
    logic [DW-1:0] exp_data;
    // A solo client-1 read parks the read pointer at client 0.
    bus.rd_vld = 2'b10; set_rd(0, 9'd1); set_rd(1, 9'd2); #1;
    n_cmp++; if (bus.rd_rdy !== 2'b10 || ram_addrb !== 9'd2) begin n_fail++; $display("FAIL solo_c1_rd: got %b/%0d want 10/2", bus.rd_rdy, ram_addrb); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); bus.rd_vld = (i < 4) ? 2'b11 : 2'b00; #1;
      if (i < 4) begin
        exp_vld = (i % 2 == 0) ? 2'b01 : 2'b10;
        n_cmp++; if (bus.rd_rdy !== exp_vld) begin n_fail++; $display("FAIL b2b_gnt[%0d]: got %b want %b", i, bus.rd_rdy, exp_vld); end
      end
      exp_vld  = (i == 0 || (i % 2 == 0)) ? 2'b10 : 2'b01;
      exp_data = (exp_vld == 2'b10) ? 72'h22 : 72'h11;
      n_cmp++; if (bus.rsp_vld !== exp_vld) begin n_fail++; $display("FAIL b2b_rsp_vld[%0d]: got %b want %b", i, bus.rsp_vld, exp_vld); end
      n_cmp++; if (bus.rsp_data !== exp_data) begin n_fail++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", i, bus.rsp_data, exp_data); end
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.rsp_vld !== 2'b00) begin n_fail++; $display("FAIL b2b_tail: got %b want 00", bus.rsp_vld); end
  endtask

  task automatic test_same_cycle();
    @(negedge clk); bus.wr_vld = 2'b01; set_wr(0, 9'd7, 72'h33);
    @(negedge clk); set_wr(0, 9'd7, 72'hFF); bus.rd_vld = 2'b01; set_rd(0, 9'd7); #1;
    n_cmp++; if (bus.wr_rdy !== 2'b01 || bus.rd_rdy !== 2'b01) begin n_fail++; $display("FAIL both_ports: got wr=%b rd=%b want 01/01", bus.wr_rdy, bus.rd_rdy); end
    @(negedge clk); bus.wr_vld = 2'b00; #1;
    n_cmp++; if (bus.rsp_vld !== 2'b01 || bus.rsp_data !== 72'h33) begin n_fail++; $display("FAIL read_first: got %b/%h want 01/33", bus.rsp_vld, bus.rsp_data); end
    @(negedge clk); bus.rd_vld = 2'b00; #1;
    n_cmp++; if (bus.rsp_vld !== 2'b01 || bus.rsp_data !== 72'hFF) begin n_fail++; $display("FAIL read_after: got %b/%h want 01/ff", bus.rsp_vld, bus.rsp_data); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); bus.rd_vld = 2'b10; set_rd(1, 9'd2); #1;
    n_cmp++; if (bus.rd_rdy !== 2'b10) begin n_fail++; $display("FAIL mid_gnt: got %b want 10", bus.rd_rdy); end
    @(negedge clk); rstn = 1'b0; bus.rd_vld = 2'b11; bus.wr_vld = 2'b11;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_cmp++; if (bus.rsp_vld !== 2'b00) begin n_fail++; $display("FAIL mid_rsp[%0d]: got %b want 00", i, bus.rsp_vld); end
      n_cmp++; if (bus.rd_rdy !== 2'b00 || bus.wr_rdy !== 2'b00) begin n_fail++; $display("FAIL mid_rdy[%0d]: got %b/%b want 00/00", i, bus.wr_rdy, bus.rd_rdy); end
    end
    @(negedge clk); rstn = 1'b1; bus.rd_vld = 2'b00; bus.wr_vld = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (bus.rsp_vld !== 2'b00) begin n_fail++; $display("FAIL post_rst_rsp: got %b want 00", bus.rsp_vld); end
    bus.rd_vld = 2'b11; bus.wr_vld = 2'b11; #1;
    n_cmp++; if (bus.wr_rdy !== 2'b01) begin n_fail++; $display("FAIL post_rst_wr_ptr: got %b want 01", bus.wr_rdy); end
    n_cmp++; if (bus.rd_rdy !== 2'b01) begin n_fail++; $display("FAIL post_rst_rd_ptr: got %b want 01", bus.rd_rdy); end
    @(negedge clk); bus.rd_vld = 2'b00; bus.wr_vld = 2'b00;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    bus.wr_vld  = '0;
    bus.rd_vld  = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;
    rstn = 1'b0;
    test_reset();
    test_write_read();
    test_write_alternate();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
